// File: rtl/bomb_neighbor_counter.sv
// -----------------------------------------------------------------------------
// bomb_neighbor_counter
//
// Annotates an 8x8 Buscaminas bomb map with the number of adjacent bombs per
// cell, one cell per clock. A start in IDLE snapshots the map and the
// expected bomb count. The scan then walks the 64 cells in row-major order
// and pulses done after the last cell. The input map may change freely while
// a scan is running because only the snapshot is read.
//
// Ports:
//   clk            - system clock, rising edge
//   rst_n          - asynchronous active-low reset
//   start          - scan request, honoured only while not busy
//   cell_matrix_in - bomb map, [r][c] = 1 means bomb at row r, column c
//   bomb_count     - expected number of bombs, captured with the map
//   count_matrix   - per-cell result: 0..8 neighbours, 4'hF = cell is a bomb
//   bomb_total     - bombs found so far (final when done pulses), 0..64
//   busy           - scan in progress
//   done           - one-cycle pulse after the last cell is written
//   mismatch       - bomb_total differs from bomb_count, valid from done
// -----------------------------------------------------------------------------
module bomb_neighbor_counter (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0][7:0]      cell_matrix_in,
    input  logic [5:0]           bomb_count,
    output logic [7:0][7:0][3:0] count_matrix,
    output logic [6:0]           bomb_total,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch
);

    localparam logic IDLE = 1'b0;
    localparam logic SCAN = 1'b1;

    logic            state;
    logic [5:0]      idx;
    logic [7:0][7:0] snap;
    logic [5:0]      exp_q;

    logic [2:0]      row;
    logic [2:0]      col;
    logic            cell_bomb;
    logic [3:0]      nbr_sum;
    logic [6:0]      total_next;

    // Sum of the in-board neighbours of (r, c). Off-board positions are
    // skipped rather than wrapped, so column 7 never sees column 0.
    function automatic logic [3:0] neighbour_sum(input logic [7:0][7:0] m,
                                                 input logic [2:0]      r,
                                                 input logic [2:0]      c);
        logic [3:0] s;
        int         rr;
        int         cc;
        s = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = int'(r) + dr;
                cc = int'(c) + dc;
                if (!(dr == 0 && dc == 0) && rr >= 0 && rr <= 7 && cc >= 0 && cc <= 7)
                    s = s + {3'b000, m[rr[2:0]][cc[2:0]]};
            end
        end
        return s;
    endfunction

    assign row        = idx[5:3];
    assign col        = idx[2:0];
    assign cell_bomb  = snap[row][col];
    assign nbr_sum    = neighbour_sum(snap, row, col);
    assign total_next = bomb_total + {6'd0, cell_bomb};
    assign busy       = (state == SCAN);

    // Snapshot of the inputs; contents are don't-care after reset, so it is
    // kept out of the reset domain.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            snap  <= cell_matrix_in;
            exp_q <= bomb_count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= 6'd0;
            count_matrix <= '0;
            bomb_total   <= 7'd0;
            done         <= 1'b0;
            mismatch     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state        <= SCAN;
                    idx          <= 6'd0;
                    count_matrix <= '0;
                    bomb_total   <= 7'd0;
                    mismatch     <= 1'b0;
                end
            end else begin
                count_matrix[row][col] <= cell_bomb ? 4'hF : nbr_sum;
                bomb_total             <= total_next;
                idx                    <= idx + 6'd1;
                // Last cell: the 63->0 wrap of idx lands in IDLE, so no
                // second pass can start without a fresh start request.
                if (idx == 6'd63) begin
                    state    <= IDLE;
                    done     <= 1'b1;
                    mismatch <= (total_next != {1'b0, exp_q});
                end
            end
        end
    end

endmodule

// File: tb/tb_bomb_neighbor_counter.sv
module tb_bomb_neighbor_counter;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [7:0][7:0]      cell_matrix_in;
    logic [5:0]           bomb_count;
    logic [7:0][7:0][3:0] count_matrix;
    logic [6:0]           bomb_total;
    logic                 busy;
    logic                 done;
    logic                 mismatch;

    int n_checks = 0;
    int n_fail   = 0;

    bomb_neighbor_counter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cell_matrix_in (cell_matrix_in),
        .bomb_count     (bomb_count),
        .count_matrix   (count_matrix),
        .bomb_total     (bomb_total),
        .busy           (busy),
        .done           (done),
        .mismatch       (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: zero-padded 10x10 board, plain sum of the 8 surrounding cells.
    function automatic logic [255:0] model_counts(input logic [7:0][7:0] m);
        int pad [10][10];
        int sum;
        logic [7:0][7:0][3:0] res;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                pad[r][c] = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                pad[r+1][c+1] = m[r][c] ? 1 : 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                sum = pad[r][c] + pad[r][c+1] + pad[r][c+2]
                    + pad[r+1][c] + pad[r+1][c+2]
                    + pad[r+2][c] + pad[r+2][c+1] + pad[r+2][c+2];
                res[r][c] = m[r][c] ? 4'hF : sum[3:0];
            end
        end
        return res;
    endfunction

    task automatic issue_start(input logic [7:0][7:0] map, input logic [5:0] bc);
        @(negedge clk);
        cell_matrix_in = map;
        bomb_count     = bc;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called just after a start edge; returns at the negedge where done is
    // seen, or after a cycle budget expires.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (!done && cyc < 200) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_results(input string tag, input logic [7:0][7:0] map, input logic [5:0] bc);
        int pc;
        pc = $countones(map);
        check_val({tag, " counts"}, count_matrix, model_counts(map));
        check_val({tag, " total"}, 256'(bomb_total), 256'(pc));
        check_val({tag, " mismatch"}, 256'(mismatch), 256'(pc != int'(bc)));
    endtask

    task automatic run_case(input string tag, input logic [7:0][7:0] map, input logic [5:0] bc);
        int cyc;
        int bcyc;
        issue_start(map, bc);
        check_val({tag, " busy_after_start"}, 256'(busy), 256'(1));
        wait_done(cyc, bcyc);
        check_val({tag, " latency"}, 256'(cyc), 256'(64));
        check_val({tag, " busy_cycles"}, 256'(bcyc), 256'(64));
        check_val({tag, " done"}, 256'(done), 256'(1));
        check_val({tag, " busy_at_done"}, 256'(busy), 256'(0));
        check_results(tag, map, bc);
        @(negedge clk);
        check_val({tag, " done_cleared"}, 256'(done), 256'(0));
        check_results({tag, " hold"}, map, bc);
    endtask

    logic [7:0][7:0] map_a;
    logic [7:0][7:0] map_b;
    logic [5:0]      bc_a;
    logic [5:0]      bc_b;
    int              cyc;
    int              bcyc;
    logic            saw_done;

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        cell_matrix_in = '0;
        bomb_count     = '0;
        repeat (3) @(negedge clk);
        check_val("reset counts", count_matrix, 256'(0));
        check_val("reset flags", {busy, done, mismatch, bomb_total}, 256'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle flags", {busy, done, mismatch, bomb_total}, 256'(0));

        // Empty board
        run_case("empty", '0, 6'd0);

        // Single bomb in the corner
        map_a = '0;
        map_a[0][0] = 1'b1;
        run_case("single", map_a, 6'd1);
        check_val("single c00", 256'(count_matrix[0][0]), 256'(4'hF));
        check_val("single c01", 256'(count_matrix[0][1]), 256'(1));
        check_val("single c11", 256'(count_matrix[1][1]), 256'(1));
        check_val("single nowrap", {count_matrix[0][7], count_matrix[1][7]}, 256'(0));

        // Ring of 8 around [4][4]
        map_a = '0;
        for (int r = 3; r <= 5; r++)
            for (int c = 3; c <= 5; c++)
                if (!(r == 4 && c == 4)) map_a[r][c] = 1'b1;
        run_case("ring", map_a, 6'd51);
        check_val("ring c44", 256'(count_matrix[4][4]), 256'(8));
        check_val("ring c22", 256'(count_matrix[2][2]), 256'(1));
        check_val("ring c24", 256'(count_matrix[2][4]), 256'(3));
        check_val("ring mismatch", 256'(mismatch), 256'(1));

        // Full board
        run_case("full", '1, 6'd63);
        check_val("full total", 256'(bomb_total), 256'(64));

        // Random boards
        for (int i = 0; i < 6; i++) begin
            map_a = {$urandom, $urandom};
            if (i % 2 == 1) map_a = map_a & {$urandom, $urandom};
            bc_a = (i % 3 == 0) ? 6'($urandom_range(0, 63)) : 6'($countones(map_a));
            run_case($sformatf("rand%0d", i), map_a, bc_a);
        end

        // Inputs toggled and start re-pulsed mid-scan; then start in done cycle
        map_a = {$urandom, $urandom};
        bc_a  = 6'($countones(map_a));
        issue_start(map_a, bc_a);
        repeat (19) @(negedge clk);
        cell_matrix_in = ~map_a;
        bomb_count     = ~bc_a;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcyc);
        check_val("restart latency", 256'(cyc), 256'(44));
        check_val("restart done", 256'(done), 256'(1));
        check_results("restart", map_a, bc_a);
        map_b = {$urandom, $urandom} & {$urandom, $urandom};
        bc_b  = 6'($urandom_range(0, 63));
        cell_matrix_in = map_b;
        bomb_count     = bc_b;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("done_start busy", 256'(busy), 256'(1));
        wait_done(cyc, bcyc);
        check_val("done_start latency", 256'(cyc), 256'(64));
        check_results("done_start", map_b, bc_b);

        // Reset in the middle of a scan
        map_a = {$urandom, $urandom};
        issue_start(map_a, 6'd5);
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midreset counts", count_matrix, 256'(0));
        check_val("midreset flags", {busy, done, mismatch, bomb_total}, 256'(0));
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check_val("midreset no_done", 256'(saw_done), 256'(0));
        map_b = {$urandom, $urandom};
        run_case("after_reset", map_b, 6'($countones(map_b)));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
